// File: rtl/cbus_sram_responder.sv
// cbus memory-side responder: single/burst reads and writes against an internal 64-bit SRAM,
// with a programmable first-beat latency. Define CBUS_RESP_STALL_EN for LFSR-driven beat stalls.
module cbus_sram_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_req_is_write,
  input  logic [2:0]  i_req_size,
  input  logic [63:0] i_req_addr,
  input  logic [7:0]  i_req_strobe,
  input  logic [63:0] i_req_data,
  input  logic [7:0]  i_req_len,
  input  logic [1:0]  i_req_burst,
  output logic        o_resp_ready,
  output logic        o_resp_last,
  output logic [63:0] o_resp_data
);
  localparam int         AW          = $clog2(MEM_WORDS);
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_addr;
  logic [7:0]    r_len, r_beat_cnt, r_lat_cnt;
  logic [1:0]    r_burst;
  logic          r_is_write;
  logic          r_resp_ready, r_resp_last;
  logic [63:0]   r_resp_data;
  logic [63:0]   r_mem [MEM_WORDS];

  logic          w_accept, w_beat, w_last_beat, w_stall, w_wrap_ok, w_in_range;
  logic [63:0]   w_wrap_mask, w_seq_addr, w_beat_addr, w_off;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // Size only matters to the initiator; full words are always returned.
  assign w_unused = ^i_req_size;

  // r_resp_last still high means the initiator has not yet seen the end of its burst.
  assign w_accept    = (r_state == S_IDLE) && i_req_valid && !r_resp_last;
  assign w_beat      = (r_state == S_BEAT) && i_req_valid && !w_stall;
  assign w_last_beat = w_beat && (r_beat_cnt == r_len);

`ifdef CBUS_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic [1:0]  r_stall_run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr      <= 16'hACE1;
      r_stall_run <= 2'd0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if ((r_state == S_BEAT) && i_req_valid && w_stall)
        r_stall_run <= r_stall_run + 2'd1;
      else
        r_stall_run <= 2'd0;
    end
  end

  assign w_stall = (r_state == S_BEAT) && r_lfsr[0] && (r_stall_run != 2'd3);
`else
  assign w_stall = 1'b0;
`endif

  // WRAP lengths are 2^n-1, so the wrap window mask is simply {len, 3'b111}.
  always_comb begin
    w_wrap_ok   = (r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15);
    w_wrap_mask = {53'd0, r_len, 3'b111};
    w_seq_addr  = r_addr + {53'd0, r_beat_cnt, 3'b000};
    if (r_burst == BURST_FIXED)
      w_beat_addr = r_addr;
    else if ((r_burst == BURST_WRAP) && w_wrap_ok)
      w_beat_addr = (r_addr & ~w_wrap_mask) | (w_seq_addr & w_wrap_mask);
    else
      w_beat_addr = w_seq_addr;
    w_off      = w_beat_addr - BASE_ADDR;
    w_in_range = (w_beat_addr >= BASE_ADDR) && ((w_off >> 3) < 64'(MEM_WORDS));
    w_idx      = w_off[AW+2:3];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!i_req_valid)           w_state_nxt = S_IDLE;
        else if (r_lat_cnt == 8'd0) w_state_nxt = S_BEAT;
      end
      S_BEAT: if (!i_req_valid || w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_burst      <= '0;
      r_is_write   <= 1'b0;
      r_beat_cnt   <= '0;
      r_lat_cnt    <= '0;
      r_resp_ready <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_ready <= w_beat;
      r_resp_last  <= w_last_beat;
      r_resp_data  <= (w_beat && !r_is_write && w_in_range) ? r_mem[w_idx] : 64'd0;
      if (w_accept) begin
        r_addr     <= i_req_addr;
        r_len      <= i_req_len;
        r_burst    <= i_req_burst;
        r_is_write <= i_req_is_write;
        r_beat_cnt <= 8'd0;
        r_lat_cnt  <= 8'(LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_lat_cnt != 8'd0)) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end
      if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

  // SRAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_beat && r_is_write && w_in_range) begin
      for (int i = 0; i < 8; i++)
        if (i_req_strobe[i]) r_mem[w_idx][8*i +: 8] <= i_req_data[8*i +: 8];
    end
  end

  assign o_resp_ready = r_resp_ready;
  assign o_resp_last  = r_resp_last;
  assign o_resp_data  = r_resp_data;

endmodule
